pwr_switch_seq: RTL and testbench

Staged power-switch sequencer for one switchable power domain, sitting directly downstream of the domain power FSM. It consumes the FSM's power-on request and drives the domain's power-switch segments one at a time, with a programmable settle delay between segments, to limit in-rush current. It returns a single aggregated power-on acknowledge to the FSM. Power-down runs in reverse segment order, and a per-segment ack timeout prevents a dead switch from hanging the FSM.

---
 rtl/pwr_switch_seq.sv | 196 +++++++++++++++++++
 tb/tb_pwr_switch_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_switch_seq.sv
// Staged power-switch sequencer for one switchable power domain.
// Turns switch segments on one at a time (low to high) with a settle delay
// between them, and off in reverse order. A per-segment ack timeout keeps a
// dead switch from stalling the domain power FSM.
module pwr_switch_seq #(
  parameter int N_SEG = 4,
  parameter int DLY_W = 8,
  parameter int TO_W  = 12
) (
  input  logic             i_aon_clk,
  input  logic             i_soc_pwr_on_rst_n,
  input  logic             i_pwr_on_req,
  input  logic [DLY_W-1:0] i_seg_dly,
  input  logic [TO_W-1:0]  i_timeout,
  input  logic [N_SEG-1:0] i_sw_ack,
  input  logic             i_err_clr,
  output logic [N_SEG-1:0] o_sw_en,
  output logic             o_pwr_on_ack,
  output logic             o_busy,
  output logic             o_timeout_err
);

  localparam int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SEG - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_UP_WAIT,
    ST_UP_DLY,
    ST_ON,
    ST_DN_WAIT,
    ST_DN_DLY
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [DLY_W-1:0] dly_cnt_reg, dly_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic [N_SEG-1:0] sw_en_next;
  logic [N_SEG-1:0] cur_oh;
  logic [N_SEG-1:0] nxt_oh;
  logic             en_set;
  logic             en_clr;
  logic             err_set;
  logic             err_next;
  logic             ack_next;
  logic             busy_next;
  logic             cur_ack;
  logic             to_expired;

  // One-hot decodes of the current and next segment index; avoids
  // out-of-range part selects when N_SEG is not a power of two.
  generate
    for (genvar gi = 0; gi < N_SEG; gi++) begin : g_idx_dec
      assign cur_oh[gi] = (idx_reg == IDX_W'(gi));
      assign nxt_oh[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

  assign cur_ack    = |(i_sw_ack & cur_oh);
  // A zero timeout disables the watchdog; otherwise expire on the cycle the
  // wait has lasted i_timeout edges.
  assign to_expired = (i_timeout != '0) && (to_cnt_reg == (i_timeout - TO_W'(1)));

  // Next-state logic; request reversal outranks ack and delay events.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    dly_cnt_next = dly_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    en_set       = 1'b0;
    en_clr       = 1'b0;
    err_set      = 1'b0;
    case (state_reg)
      ST_OFF: begin
        if (i_pwr_on_req) begin
          idx_next    = '0;
          en_set      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_UP_WAIT;
        end
      end
      ST_UP_WAIT: begin
        if (!i_pwr_on_req) begin
          en_clr      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_DN_WAIT;
        end else if (cur_ack || to_expired) begin
          err_set = !cur_ack;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_ON;
          end else begin
            dly_cnt_next = i_seg_dly;
            state_next   = ST_UP_DLY;
          end
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      ST_UP_DLY: begin
        if (!i_pwr_on_req) begin
          en_clr      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_DN_WAIT;
        end else if (dly_cnt_reg == '0) begin
          idx_next    = idx_reg + IDX_W'(1);
          en_set      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_UP_WAIT;
        end else begin
          dly_cnt_next = dly_cnt_reg - DLY_W'(1);
        end
      end
      ST_ON: begin
        if (!i_pwr_on_req) begin
          en_clr      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_DN_WAIT;
        end
      end
      ST_DN_WAIT: begin
        if (i_pwr_on_req) begin
          en_set      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_UP_WAIT;
        end else if (!cur_ack || to_expired) begin
          err_set = cur_ack;
          if (idx_reg == '0) begin
            state_next = ST_OFF;
          end else begin
            dly_cnt_next = i_seg_dly;
            state_next   = ST_DN_DLY;
          end
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      ST_DN_DLY: begin
        if (i_pwr_on_req) begin
          en_set      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_UP_WAIT;
        end else if (dly_cnt_reg == '0) begin
          idx_next    = idx_reg - IDX_W'(1);
          en_clr      = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_DN_WAIT;
        end else begin
          dly_cnt_next = dly_cnt_reg - DLY_W'(1);
        end
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase
  end

  // Output next values: enables move one bit at a time so they stay a
  // thermometer code; a new timeout beats a simultaneous clear.
  always_comb begin
    sw_en_next = o_sw_en;
    if (en_set) begin
      sw_en_next = o_sw_en | nxt_oh;
    end else if (en_clr) begin
      sw_en_next = o_sw_en & ~nxt_oh;
    end
    ack_next  = (state_next == ST_ON);
    busy_next = (state_next == ST_UP_WAIT) || (state_next == ST_UP_DLY) ||
                (state_next == ST_DN_WAIT) || (state_next == ST_DN_DLY);
    err_next  = err_set || (o_timeout_err && !i_err_clr);
  end

  // State and registered outputs; reset drops every enable immediately.
  always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
    if (!i_soc_pwr_on_rst_n) begin
      state_reg     <= ST_OFF;
      idx_reg       <= '0;
      dly_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      o_sw_en       <= '0;
      o_pwr_on_ack  <= 1'b0;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      dly_cnt_reg   <= dly_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      o_sw_en       <= sw_en_next;
      o_pwr_on_ack  <= ack_next;
      o_busy        <= busy_next;
      o_timeout_err <= err_next;
    end
  end

endmodule

// File: tb/tb_pwr_switch_seq.sv
// Directed bench for pwr_switch_seq: a 4-segment instance and a 1-segment
// instance. Expected output snapshots are queued with the edge they belong
// to and compared on the following falling clock edge.
module tb_pwr_switch_seq;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [7:0]  seg_dly;
  logic [11:0] timeout;
  logic [3:0]  sw_ack;
  logic        err_clr;
  logic [3:0]  sw_en;
  logic        pwr_on_ack;
  logic        busy;
  logic        terr;
  logic [3:0]  ack_mask;
  logic [3:0]  ack_force;

  logic        req1;
  logic [0:0]  sw_ack1;
  logic [0:0]  sw_en1;
  logic        pwr_on_ack1;
  logic        busy1;
  logic        terr1;
  logic        ack_mask1;

  // Switch model: ack follows enable, with per-segment stuck-low / stuck-high
  assign sw_ack  = (sw_en & ack_mask) | ack_force;
  assign sw_ack1 = sw_en1 & ack_mask1;

  pwr_switch_seq #(.N_SEG(4), .DLY_W(8), .TO_W(12)) u_dut (
    .i_aon_clk          (clk),
    .i_soc_pwr_on_rst_n (rst_n),
    .i_pwr_on_req       (req),
    .i_seg_dly          (seg_dly),
    .i_timeout          (timeout),
    .i_sw_ack           (sw_ack),
    .i_err_clr          (err_clr),
    .o_sw_en            (sw_en),
    .o_pwr_on_ack       (pwr_on_ack),
    .o_busy             (busy),
    .o_timeout_err      (terr)
  );

  pwr_switch_seq #(.N_SEG(1), .DLY_W(8), .TO_W(12)) u_dut1 (
    .i_aon_clk          (clk),
    .i_soc_pwr_on_rst_n (rst_n),
    .i_pwr_on_req       (req1),
    .i_seg_dly          (8'd0),
    .i_timeout          (12'd0),
    .i_sw_ack           (sw_ack1),
    .i_err_clr          (1'b0),
    .o_sw_en            (sw_en1),
    .o_pwr_on_ack       (pwr_on_ack1),
    .o_busy             (busy1),
    .o_timeout_err      (terr1)
  );

  typedef struct {
    int         edge_no;
    int         dut;
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   base     = 0;
  int   checks   = 0;
  int   errors   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Packs {en[3:0], ack, busy, err} for comparison
  function automatic logic [6:0] mk(input logic [3:0] en, input logic a,
                                    input logic b, input logic e);
    return {en, a, b, e};
  endfunction

  function automatic logic [6:0] obs_of(input int dut);
    if (dut == 0) return {sw_en, pwr_on_ack, busy, terr};
    return {3'b000, sw_en1, pwr_on_ack1, busy1, terr1};
  endfunction

  task automatic expect_at(input int rel, input int dut, input string tag,
                           input logic [6:0] val);
    exp_t e;
    e.edge_no = base + rel;
    e.dut     = dut;
    e.tag     = tag;
    e.val     = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed en/ack/busy/err=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic sync_to(input int abs_edge);
    while (edge_cnt < abs_edge) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop every snapshot due at or before the latest edge
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      exp_t e;
      logic [6:0] obs;
      e   = exp_q.pop_front();
      obs = obs_of(e.dut);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s edge=%0d observed en/ack/busy/err=%b expected=%b",
               e.tag, e.edge_no, obs, e.val);
      end
      $display("check %-14s edge=%0d dut=%0d obs=%b exp=%b", e.tag, e.edge_no, e.dut, obs, e.val);
    end
  end

  initial begin
    rst_n     = 1'b1;
    req       = 1'b0;
    req1      = 1'b0;
    seg_dly   = 8'd2;
    timeout   = 12'd0;
    err_clr   = 1'b0;
    ack_mask  = 4'hF;
    ack_force = 4'h0;
    ack_mask1 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", obs_of(0), mk(4'b0000, 0, 0, 0));
    chk("rst_async1", obs_of(1), mk(4'b0000, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = edge_cnt;
    expect_at(0, 0, "rst_state", mk(4'b0000, 0, 0, 0));

    // Power-up, D=2, ack follows enable
    sync_to(base + 1);
    base = edge_cnt;
    req = 1'b1;
    expect_at(1,  0, "up_e1",  mk(4'b0001, 0, 1, 0));
    expect_at(4,  0, "up_e4",  mk(4'b0001, 0, 1, 0));
    expect_at(5,  0, "up_e5",  mk(4'b0011, 0, 1, 0));
    expect_at(9,  0, "up_e9",  mk(4'b0111, 0, 1, 0));
    expect_at(13, 0, "up_e13", mk(4'b1111, 0, 1, 0));
    expect_at(14, 0, "up_on",  mk(4'b1111, 1, 0, 0));
    sync_to(base + 15);

    // Power-down from ON
    base = edge_cnt;
    req = 1'b0;
    expect_at(1,  0, "dn_k",    mk(4'b0111, 0, 1, 0));
    expect_at(4,  0, "dn_k3",   mk(4'b0111, 0, 1, 0));
    expect_at(5,  0, "dn_k4",   mk(4'b0011, 0, 1, 0));
    expect_at(9,  0, "dn_k8",   mk(4'b0001, 0, 1, 0));
    expect_at(13, 0, "dn_k12",  mk(4'b0000, 0, 1, 0));
    expect_at(14, 0, "dn_off",  mk(4'b0000, 0, 0, 0));
    sync_to(base + 14);

    // Timeout: ack[1] stuck low, i_timeout=10
    base = edge_cnt;
    ack_mask = 4'b1101;
    timeout  = 12'd10;
    req = 1'b1;
    expect_at(5,  0, "to_en1",    mk(4'b0011, 0, 1, 0));
    expect_at(14, 0, "to_before", mk(4'b0011, 0, 1, 0));
    expect_at(15, 0, "to_err",    mk(4'b0011, 0, 1, 1));
    expect_at(17, 0, "to_dly",    mk(4'b0011, 0, 1, 1));
    expect_at(18, 0, "to_adv",    mk(4'b0111, 0, 1, 1));
    expect_at(23, 0, "to_on",     mk(4'b1111, 1, 0, 1));
    sync_to(base + 24);
    err_clr = 1'b1;
    expect_at(25, 0, "err_clr",   mk(4'b1111, 1, 0, 0));
    sync_to(base + 25);
    err_clr  = 1'b0;
    ack_mask = 4'hF;
    timeout  = 12'd0;

    // Back to OFF
    base = edge_cnt;
    req = 1'b0;
    expect_at(14, 0, "off_again", mk(4'b0000, 0, 0, 0));
    sync_to(base + 14);

    // Reversal during power-up, in UP_DLY with 0011
    base = edge_cnt;
    req = 1'b1;
    expect_at(5, 0, "rv_up5", mk(4'b0011, 0, 1, 0));
    expect_at(6, 0, "rv_dly", mk(4'b0011, 0, 1, 0));
    sync_to(base + 6);
    req = 1'b0;
    expect_at(7,  0, "rv_drop",  mk(4'b0001, 0, 1, 0));
    expect_at(10, 0, "rv_hold",  mk(4'b0001, 0, 1, 0));
    expect_at(11, 0, "rv_clr0",  mk(4'b0000, 0, 1, 0));
    expect_at(12, 0, "rv_off",   mk(4'b0000, 0, 0, 0));
    sync_to(base + 12);

    // Reversal during power-down, held in DN_WAIT at idx 0
    base = edge_cnt;
    req = 1'b1;
    expect_at(14, 0, "rv2_on", mk(4'b1111, 1, 0, 0));
    sync_to(base + 14);
    base = edge_cnt;
    ack_force = 4'b0001;
    req = 1'b0;
    expect_at(1,  0, "rv2_dn1",   mk(4'b0111, 0, 1, 0));
    expect_at(5,  0, "rv2_dn5",   mk(4'b0011, 0, 1, 0));
    expect_at(9,  0, "rv2_dn9",   mk(4'b0001, 0, 1, 0));
    expect_at(13, 0, "rv2_dn13",  mk(4'b0000, 0, 1, 0));
    expect_at(16, 0, "rv2_stuck", mk(4'b0000, 0, 1, 0));
    sync_to(base + 16);
    req = 1'b1;
    ack_force = 4'b0000;
    expect_at(17, 0, "rv2_re",   mk(4'b0001, 0, 1, 0));
    expect_at(21, 0, "rv2_up",   mk(4'b0011, 0, 1, 0));
    expect_at(30, 0, "rv2_on2",  mk(4'b1111, 1, 0, 0));
    sync_to(base + 30);

    // Asynchronous reset mid power-down with 0111
    base = edge_cnt;
    req = 1'b0;
    expect_at(1, 0, "rs_pre", mk(4'b0111, 0, 1, 0));
    sync_to(base + 1);
    #6;
    rst_n = 1'b0;
    #1;
    chk("rs_async", obs_of(0), mk(4'b0000, 0, 0, 0));
    @(posedge clk);
    #1;
    base = edge_cnt;
    expect_at(0, 0, "rs_held", mk(4'b0000, 0, 0, 0));
    req   = 1'b1;
    rst_n = 1'b1;
    expect_at(1, 0, "rs_restart", mk(4'b0001, 0, 1, 0));
    expect_at(5, 0, "rs_seg1",    mk(4'b0011, 0, 1, 0));
    sync_to(base + 5);

    // Single-segment instance, D=0, no timeout
    base = edge_cnt;
    req1 = 1'b1;
    expect_at(1, 1, "s1_en",   mk(4'b0001, 0, 1, 0));
    expect_at(2, 1, "s1_ack",  mk(4'b0001, 1, 0, 0));
    sync_to(base + 2);
    req1 = 1'b0;
    expect_at(3, 1, "s1_dn",   mk(4'b0000, 0, 1, 0));
    expect_at(4, 1, "s1_off",  mk(4'b0000, 0, 0, 0));
    sync_to(base + 4);
    base = edge_cnt;
    ack_mask1 = 1'b0;
    req1 = 1'b1;
    expect_at(1,  1, "s1_wait",  mk(4'b0001, 0, 1, 0));
    expect_at(20, 1, "s1_stuck", mk(4'b0001, 0, 1, 0));
    sync_to(base + 20);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
